// File: rtl/seq_divide_pkg.sv
// Shared types and sizing for the sequential divider.
package seq_divide_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Iteration counter must hold the value 2W.
  function automatic int cnt_w(input int w);
    return $clog2(2 * w) + 1;
  endfunction

endpackage

// File: rtl/seq_divide_if.sv
// Request/result bundle between a controller and the divider (level start / rdy handshake).
interface seq_divide_if
  import seq_divide_pkg::*;
#(
  parameter int W = W_DEF
);

  logic             start;
  logic [2*W-1:0]   dvd;
  logic [W-1:0]     dvs;
  logic [2*W-1:0]   quo;
  logic [W-1:0]     rem;
  logic             rdy;
  logic             dz;

  modport master (output start, dvd, dvs, input quo, rem, rdy, dz);
  modport slave  (input start, dvd, dvs, output quo, rem, rdy, dz);

endinterface

// File: rtl/seq_divide_step.sv
// One restoring-division step: shift in dividend MSB, trial-subtract, keep or restore.
// Purely combinational, no latency and no handshake.
module seq_divide_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_in,
  input  logic         msb,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_out,
  output logic         qbit
);

  logic [W:0]   shifted;
  logic [W+1:0] diff;

  assign shifted = {rem_in, msb};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};
  assign qbit    = ~diff[W+1];
  // A kept difference is below dvs and a restored value was below dvs, so W bits suffice.
  assign rem_out = W'(qbit ? diff : {1'b0, shifted});

endmodule

// File: rtl/seq_divide.sv
// Restoring divider (2W / W), one quotient bit per clock; SEQ_DIVIDE_SIGNED_EN adds two's complement mode.
// Result 2W edges after load (1 edge for /0); level start/rdy handshake, result held until start drops.
module seq_divide
  import seq_divide_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_divide_if.slave bus
);

  localparam int CW = cnt_w(W);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  dq;
  logic [W-1:0]    pr;
  logic [W-1:0]    dvs_r;
  logic [2*W-1:0]  dvd_mag;
  logic [W-1:0]    dvs_mag;
  logic [W-1:0]    step_rem;
  logic            qbit;
  logic [2*W-1:0]  q_next;
  logic [2*W-1:0]  q_fix;
  logic [W-1:0]    r_fix;

  seq_divide_step #(.W(W)) u_step (
    .rem_in  (pr),
    .msb     (dq[2*W-1]),
    .dvs     (dvs_r),
    .rem_out (step_rem),
    .qbit    (qbit)
  );

  assign q_next = {dq[2*W-2:0], qbit};

`ifdef SEQ_DIVIDE_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign dvd_mag = bus.dvd[2*W-1] ? -bus.dvd : bus.dvd;
  assign dvs_mag = bus.dvs[W-1]   ? -bus.dvs : bus.dvs;
  // Truncation toward zero; remainder follows the dividend sign.
  assign q_fix   = neg_q ? -q_next   : q_next;
  assign r_fix   = neg_r ? -step_rem : step_rem;
`else
  assign dvd_mag = bus.dvd;
  assign dvs_mag = bus.dvs;
  assign q_fix   = q_next;
  assign r_fix   = step_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      dq      <= '0;
      pr      <= '0;
      dvs_r   <= '0;
      bus.quo <= '0;
      bus.rem <= '0;
      bus.rdy <= 1'b0;
      bus.dz  <= 1'b0;
`ifdef SEQ_DIVIDE_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt   <= '0;
            pr    <= '0;
            dvs_r <= dvs_mag;
`ifdef SEQ_DIVIDE_SIGNED_EN
            neg_q <= bus.dvd[2*W-1] ^ bus.dvs[W-1];
            neg_r <= bus.dvd[2*W-1];
`endif
            // Divide by zero keeps the raw dividend: its low half becomes the remainder.
            if (bus.dvs == '0) begin
              dq    <= bus.dvd;
              state <= DONE;
            end else begin
              dq    <= dvd_mag;
              state <= RUN;
            end
          end
        end
        RUN: begin
          pr  <= step_rem;
          dq  <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(2 * W - 1)) begin
            state   <= DONE;
            bus.quo <= q_fix;
            bus.rem <= r_fix;
            bus.dz  <= 1'b0;
            bus.rdy <= 1'b1;
          end
        end
        DONE: begin
          // Only the divide-by-zero path arrives here with rdy still low.
          if (!bus.rdy) begin
            bus.quo <= '1;
            bus.rem <= dq[W-1:0];
            bus.dz  <= 1'b1;
            bus.rdy <= 1'b1;
          end else if (!bus.start) begin
            bus.rdy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
